// File: rtl/dsp_pipe_stage.sv
// Multi-stage enable/clear pipeline register with a per-stage valid sideband.
// Optional occupancy counter output is enabled by defining DSP_PIPE_OCCUPANCY_EN.
module dsp_pipe_stage #(
    parameter int WIDTH        = 18,
    parameter int DEPTH        = 2,
    parameter int ZERO_INVALID = 0,
    localparam int OCC_W       = (DEPTH < 1) ? 1 : $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clk_EN,
    input  logic             sclr,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
`ifdef DSP_PIPE_OCCUPANCY_EN
    ,
    output logic [OCC_W-1:0] occupancy
`endif
);

    // Invalid beats carry zero data when ZERO_INVALID is set, so X never leaks past a stage.
    function automatic logic [WIDTH-1:0] gate_data(input logic [WIDTH-1:0] x, input logic v);
        if ((ZERO_INVALID != 0) && !v) begin
            return '0;
        end
        return x;
    endfunction

    generate
        if (DEPTH == 0) begin : g_bypass
            assign q       = gate_data(d, d_valid);
            assign q_valid = d_valid;
`ifdef DSP_PIPE_OCCUPANCY_EN
            assign occupancy = '0;
`endif
        end else begin : g_pipe
            logic [WIDTH-1:0] data_p [DEPTH];
            logic [DEPTH-1:0] vld_p;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        data_p[i] <= '0;
                    end
                    vld_p <= '0;
                end else if (sclr) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        data_p[i] <= '0;
                    end
                    vld_p <= '0;
                end else if (clk_EN) begin
                    // stage 0 captures the input; later stages shift in lockstep
                    data_p[0] <= gate_data(d, d_valid);
                    vld_p[0]  <= d_valid;
                    for (int i = 1; i < DEPTH; i++) begin
                        data_p[i] <= gate_data(data_p[i-1], vld_p[i-1]);
                        vld_p[i]  <= vld_p[i-1];
                    end
                end
            end

            assign q       = data_p[DEPTH-1];
            assign q_valid = vld_p[DEPTH-1];

`ifdef DSP_PIPE_OCCUPANCY_EN
            logic [OCC_W-1:0] occ_q;

            // Incremental count: one beat may enter and one may leave per advancing edge.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    occ_q <= '0;
                end else if (sclr) begin
                    occ_q <= '0;
                end else if (clk_EN) begin
                    occ_q <= occ_q + OCC_W'(d_valid) - OCC_W'(vld_p[DEPTH-1]);
                end
            end

            assign occupancy = occ_q;
`endif
        end
    endgenerate

endmodule

// File: doc/dsp_pipe_stage.md
Name: dsp_pipe_stage

Overview:
- Parametrised multi-stage pipeline register for the DSP48A1 datapath (A/B/C/D/M/P register slots); next generation of the single-stage enable/reset flop.
- Adds configurable width and depth, a valid sideband per stage, a synchronous clear, and optional zeroing of invalid data.
- Instantiated wherever the slice needs a programmable register count (e.g. A0/A1, B0/B1 cascades); DEPTH=0 gives a combinational bypass.

Parameters:
- WIDTH, 18, data width in bits (1..48).
- DEPTH, 2, number of register stages (0..8); 0 means combinational bypass.
- ZERO_INVALID, 0, when 1 a stage loads all-zero data whenever its incoming valid is 0.

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  asynchronous reset, active-low; clears every stage immediately.
- clk_EN  input  1  stage-advance enable, active-high.
- sclr  input  1  synchronous clear, active-high.
- d  input  WIDTH  data into stage 0.
- d_valid  input  1  valid qualifier for d.
- q  output  WIDTH  data from the last stage.
- q_valid  output  1  valid from the last stage.

Behaviour:
- Reset: rstn=0 asynchronously forces all stage data and valid bits to 0, so q=0 and q_valid=0 while rstn is low. The first capture happens on the first rising clk edge after rstn returns high.
- Priority at each rising clk edge: rstn low, then sclr, then clk_EN, then hold.
- sclr=1: every stage's data and valid bits go to 0 on the edge, regardless of clk_EN.
- clk_EN=1 and sclr=0:
  - stage[0] <= d and v[0] <= d_valid.
  - stage[i] <= stage[i-1] and v[i] <= v[i-1] for i = 1..DEPTH-1.
  - All stages advance together; there is no bubble collapse.
- clk_EN=0 and sclr=0: all stages hold.
- Outputs: q = stage[DEPTH-1] and q_valid = v[DEPTH-1], driven directly from flops with no output logic.
- Latency: with clk_EN held at 1, d presented before edge k appears on q after edge k+DEPTH-1, i.e. DEPTH edges. Deasserted clk_EN cycles stretch latency by one per cycle.
- ZERO_INVALID=1: a stage whose incoming valid is 0 loads 0 instead of its incoming data; valid propagates unchanged. ZERO_INVALID=0: data propagates regardless of valid.
- DEPTH=0: q=d and q_valid=d_valid combinationally (ZERO_INVALID still applies); clk, rstn, clk_EN and sclr have no effect; no flops are inferred.
- Reset or sclr mid-stream: in-flight data is discarded, never replayed. The next valid output is the first d_valid=1 captured after the clear, DEPTH advancing edges later.
- Back-to-back valid beats with clk_EN=1 give full throughput, one beat per cycle, with no gaps.
- X on d while d_valid=0 must not reach q when ZERO_INVALID=1.

Optional Feature:
- Macro: DSP_PIPE_OCCUPANCY_EN.
- Defined:
  - Adds output port occupancy, width $clog2(DEPTH+1) with a minimum of 1 bit.
  - occupancy is a registered count of set valid bits across all stages.
  - Updated incrementally on each advancing edge: +1 if d_valid enters, -1 if v[DEPTH-1] leaves, net 0 if both or neither.
  - Cleared by rstn (async) and by sclr (sync); held when clk_EN=0.
  - Constant 0 when DEPTH=0.
- Not defined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- WIDTH=18, DEPTH=2: after reset, drive d=0x00001 with valid, then d=0x00002 with valid, clk_EN=1 -> q=0x00001 with q_valid=1 after the 2nd edge; q=0x00002 after the 3rd; q_valid=0 after the 4th if d_valid drops.
- DEPTH=3: stream 0x10,0x11,0x12 with clk_EN=1, deassert clk_EN for 2 cycles mid-stream -> q holds its value for exactly 2 cycles; output order is 0x10,0x11,0x12 with no loss.
- DEPTH=2: pipe full of valid data, assert sclr and clk_EN together for one edge -> q=0 and q_valid=0 after that edge; the next valid input appears 2 edges later.
- DEPTH=2: drop rstn asynchronously between edges with the pipe full -> q=0 and q_valid=0 before the next edge; release rstn -> no output until new data has been clocked through.
- DEPTH=0, ZERO_INVALID=1: d=0x3FFFF with d_valid=0 -> q=0 combinationally; d_valid=1 -> q=0x3FFFF in the same cycle.
- DSP_PIPE_OCCUPANCY_EN, DEPTH=4: push 3 valid beats then 1 invalid -> occupancy reads 1,2,3,3; next invalid edge -> 2; sclr -> 0.
